// File: rtl/coletor_pkg.sv
// Shared types for the measurement collector: FSM state encoding, classifier codes
// and the three-sample bundle with its ascending sort helper.
package coletor_pkg;

  localparam int MEDIDA_W = 12;

  typedef enum logic [3:0] {
    ST_OCIOSO         = 4'd0,
    ST_DISPARA        = 4'd1,
    ST_ESPERA_MEDIDA  = 4'd2,
    ST_ARMAZENA       = 4'd3,
    ST_INTERVALO      = 4'd4,
    ST_ZERA_CLASSIF   = 4'd5,
    ST_INICIA_CLASSIF = 4'd6,
    ST_ESPERA_CLASSIF = 4'd7,
    ST_AVALIA         = 4'd8,
    ST_PRONTO         = 4'd9,
    ST_ERRO           = 4'd10,
    ST_ORDENA         = 4'd11
  } estado_t;

  typedef enum logic [2:0] {
    BAIXO      = 3'b001,
    ALTO       = 3'b010,
    MUITO_ALTO = 3'b011,
    NORMAL     = 3'b100
  } classif_t;

  typedef struct packed {
    logic [MEDIDA_W-1:0] m1;
    logic [MEDIDA_W-1:0] m2;
    logic [MEDIDA_W-1:0] m3;
  } trio_t;

  // Three compare-exchange steps give a full ascending sort of three values.
  function automatic trio_t ordena3(input trio_t t);
    trio_t s;
    logic [MEDIDA_W-1:0] tmp;
    s = t;
    if (s.m1 > s.m2) begin tmp = s.m1; s.m1 = s.m2; s.m2 = tmp; end
    if (s.m2 > s.m3) begin tmp = s.m2; s.m2 = s.m3; s.m3 = tmp; end
    if (s.m1 > s.m2) begin tmp = s.m1; s.m1 = s.m2; s.m2 = tmp; end
    return s;
  endfunction

endpackage

// File: rtl/contador_limite.sv
// Saturating up-counter with synchronous clear and enable; o_fim flags LIMITE-1.
module contador_limite #(
  parameter int LIMITE = 4
) (
  input  logic clock,
  input  logic zera_n,
  input  logic i_limpa,
  input  logic i_habilita,
  output logic o_fim
);

  localparam int W = (LIMITE > 1) ? $clog2(LIMITE) : 1;
  localparam logic [W-1:0] FINAL = W'(LIMITE - 1);

  logic [W-1:0] r_conta;

  always_ff @(posedge clock) begin
    if (!zera_n || i_limpa)
      r_conta <= '0;
    else if (i_habilita && (r_conta != FINAL))
      r_conta <= r_conta + 1'b1;
  end

  assign o_fim = (r_conta == FINAL);

endmodule

// File: rtl/coletor_medidas.sv
// Acquisition sequencer: three spaced sensor readings, classifier run, bounded retries.
// Optional COLETOR_MEDIANA_EN adds an ORDENA state that sorts the samples ascending.
module coletor_medidas
  import coletor_pkg::*;
#(
  parameter int INTERVALO      = 50000,
  parameter int TIMEOUT        = 2000000,
  parameter int MAX_TENTATIVAS = 3
) (
  input  logic                clock,
  input  logic                zera_n,
  input  logic                medir,
  input  logic                pronto_sensor,
  input  logic [MEDIDA_W-1:0] medida_sensor,
  input  logic                fim_classificacao,
  input  logic                descartar_medida,
  input  logic [MEDIDA_W-1:0] media,
  input  logic [2:0]          medida_classificacao,
  output logic                trigger,
  output logic [MEDIDA_W-1:0] medida1,
  output logic [MEDIDA_W-1:0] medida2,
  output logic [MEDIDA_W-1:0] medida3,
  output logic                zera_classificador,
  output logic                iniciar,
  output logic                pronto,
  output logic                descartada,
  output logic                erro_timeout,
  output logic [2:0]          tentativas,
  output logic [MEDIDA_W-1:0] media_final,
  output logic [2:0]          classificacao_final
);

`ifdef COLETOR_MEDIANA_EN
  localparam estado_t ST_POS_AMOSTRAS = ST_ORDENA;
`else
  localparam estado_t ST_POS_AMOSTRAS = ST_ZERA_CLASSIF;
`endif

  estado_t             r_estado, w_prox;
  trio_t               r_amostras;
  logic [1:0]          r_indice;
  logic [2:0]          r_tent;
  logic [MEDIDA_W-1:0] r_media_f;
  logic [2:0]          r_classif_f;
  logic                r_pronto, r_descartada, r_erro;
  logic                r_trigger, r_zera, r_iniciar;
  logic                w_fim_int, w_fim_to, w_inicio, w_repete;
  logic                w_prox_trigger, w_prox_zera, w_prox_iniciar;

  contador_limite #(.LIMITE(INTERVALO)) u_cnt_intervalo (
    .clock      (clock),
    .zera_n     (zera_n),
    .i_limpa    (r_estado != ST_INTERVALO),
    .i_habilita (1'b1),
    .o_fim      (w_fim_int)
  );

  contador_limite #(.LIMITE(TIMEOUT)) u_cnt_timeout (
    .clock      (clock),
    .zera_n     (zera_n),
    .i_limpa    (r_estado != ST_ESPERA_MEDIDA),
    .i_habilita (1'b1),
    .o_fim      (w_fim_to)
  );

  assign w_inicio = medir && ((r_estado == ST_OCIOSO) || (r_estado == ST_PRONTO) ||
                              (r_estado == ST_ERRO));
  assign w_repete = descartar_medida && (r_tent < 3'(MAX_TENTATIVAS));

  always_ff @(posedge clock) begin
    if (!zera_n) r_estado <= ST_OCIOSO;
    else         r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      ST_OCIOSO, ST_PRONTO, ST_ERRO: if (medir) w_prox = ST_DISPARA;
      ST_DISPARA:        w_prox = ST_ESPERA_MEDIDA;
      // A sensor answer on the last timeout cycle still counts as a sample.
      ST_ESPERA_MEDIDA:  if (pronto_sensor) w_prox = ST_ARMAZENA;
                         else if (w_fim_to) w_prox = ST_ERRO;
      ST_ARMAZENA:       w_prox = (r_indice == 2'd2) ? ST_POS_AMOSTRAS : ST_INTERVALO;
      ST_INTERVALO:      if (w_fim_int) w_prox = ST_DISPARA;
`ifdef COLETOR_MEDIANA_EN
      ST_ORDENA:         w_prox = ST_ZERA_CLASSIF;
`endif
      ST_ZERA_CLASSIF:   w_prox = ST_INICIA_CLASSIF;
      ST_INICIA_CLASSIF: w_prox = ST_ESPERA_CLASSIF;
      ST_ESPERA_CLASSIF: if (fim_classificacao) w_prox = ST_AVALIA;
      ST_AVALIA:         w_prox = w_repete ? ST_INTERVALO : ST_PRONTO;
      default:           w_prox = ST_OCIOSO;
    endcase
  end

  // Pulses are registered from the next state so they coincide with state residency.
  always_comb begin
    w_prox_trigger = (w_prox == ST_DISPARA);
    w_prox_zera    = (w_prox == ST_ZERA_CLASSIF);
    w_prox_iniciar = (w_prox == ST_INICIA_CLASSIF);
  end

  always_ff @(posedge clock) begin
    if (!zera_n) begin
      r_trigger    <= 1'b0;
      r_zera       <= 1'b0;
      r_iniciar    <= 1'b0;
      r_amostras   <= '0;
      r_indice     <= '0;
      r_tent       <= '0;
      r_media_f    <= '0;
      r_classif_f  <= '0;
      r_pronto     <= 1'b0;
      r_descartada <= 1'b0;
      r_erro       <= 1'b0;
    end else begin
      r_trigger <= w_prox_trigger;
      r_zera    <= w_prox_zera;
      r_iniciar <= w_prox_iniciar;
      if (w_inicio) begin
        r_tent       <= 3'd1;
        r_indice     <= '0;
        r_pronto     <= 1'b0;
        r_descartada <= 1'b0;
        r_erro       <= 1'b0;
      end
      if ((r_estado == ST_ESPERA_MEDIDA) && pronto_sensor) begin
        unique case (r_indice)
          2'd0:    r_amostras.m1 <= medida_sensor;
          2'd1:    r_amostras.m2 <= medida_sensor;
          default: r_amostras.m3 <= medida_sensor;
        endcase
      end
      if ((r_estado == ST_ESPERA_MEDIDA) && (w_prox == ST_ERRO))
        r_erro <= 1'b1;
      if ((r_estado == ST_ARMAZENA) && (r_indice != 2'd2))
        r_indice <= r_indice + 2'd1;
`ifdef COLETOR_MEDIANA_EN
      if (r_estado == ST_ORDENA)
        r_amostras <= ordena3(r_amostras);
`endif
      if (r_estado == ST_AVALIA) begin
        if (w_repete) begin
          r_tent   <= r_tent + 3'd1;
          r_indice <= '0;
        end else begin
          r_media_f    <= media;
          r_classif_f  <= medida_classificacao;
          r_descartada <= descartar_medida;
          r_pronto     <= 1'b1;
        end
      end
    end
  end

  assign trigger             = r_trigger;
  assign zera_classificador  = r_zera;
  assign iniciar             = r_iniciar;
  assign medida1             = r_amostras.m1;
  assign medida2             = r_amostras.m2;
  assign medida3             = r_amostras.m3;
  assign pronto              = r_pronto;
  assign descartada          = r_descartada;
  assign erro_timeout        = r_erro;
  assign tentativas          = r_tent;
  assign media_final         = r_media_f;
  assign classificacao_final = r_classif_f;

endmodule

// File: tb/tb_coletor_medidas.sv
// Bench for coletor_medidas: behavioural sensor and classifier models plus an
// acquisition-level reference (attempt count, chosen sample set, latched result).
`timescale 1ns/1ps
module tb_coletor_medidas;
  import coletor_pkg::*;

  localparam int INTERVALO = 4;
  localparam int TIMEOUT   = 20;
  localparam int MAX_TENT  = 2;
  // Cycles spent waiting for the sensor / classifier models below.
  localparam int ESPERA_SENSOR  = 2;
  localparam int ESPERA_CLASSIF = 3;
`ifdef COLETOR_MEDIANA_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  // Per sample: DISPARA + sensor wait + ARMAZENA; then two intervals, clear,
  // start, classifier wait, evaluation.
  localparam int LAT_1 = 3 * (2 + ESPERA_SENSOR) + 2 * INTERVALO + 2 + ESPERA_CLASSIF + 1 + EXTRA;

  logic        clock = 1'b0;
  logic        zera_n, medir;
  logic        pronto_sensor;
  logic [11:0] medida_sensor;
  logic        trigger, zera_classificador, iniciar, pronto, descartada, erro_timeout;
  logic [11:0] medida1, medida2, medida3, media_final;
  logic [2:0]  tentativas, classificacao_final;

  logic        fim_c = 1'b0, desc_c = 1'b0;
  logic [11:0] media_c = '0;
  logic [2:0]  cod_c = '0;

  always #5 clock = ~clock;

  coletor_medidas #(.INTERVALO(INTERVALO), .TIMEOUT(TIMEOUT), .MAX_TENTATIVAS(MAX_TENT)) dut (
    .clock                (clock),
    .zera_n               (zera_n),
    .medir                (medir),
    .pronto_sensor        (pronto_sensor),
    .medida_sensor        (medida_sensor),
    .fim_classificacao    (fim_c),
    .descartar_medida     (desc_c),
    .media                (media_c),
    .medida_classificacao (cod_c),
    .trigger              (trigger),
    .medida1              (medida1),
    .medida2              (medida2),
    .medida3              (medida3),
    .zera_classificador   (zera_classificador),
    .iniciar              (iniciar),
    .pronto               (pronto),
    .descartada           (descartada),
    .erro_timeout         (erro_timeout),
    .tentativas           (tentativas),
    .media_final          (media_final),
    .classificacao_final  (classificacao_final)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sensor model: answers each trigger ESPERA_SENSOR cycles into ESPERA_MEDIDA with the next queued value.
  logic [11:0] sens_q[$];
  logic        resp_ps = 1'b0, poke_ps = 1'b0;
  logic [11:0] resp_val = '0, poke_val = '0;
  assign pronto_sensor = resp_ps | poke_ps;
  assign medida_sensor = poke_ps ? poke_val : resp_val;

  always begin
    @(negedge clock);
    if (trigger && sens_q.size() > 0) begin
      resp_val = sens_q.pop_front();
      @(posedge clock);
      @(posedge clock);
      #1 resp_ps = 1'b1;
      @(posedge clock);
      #1 resp_ps = 1'b0;
    end
  end

  // Classifier model: cleared by zera_classificador, done two cycles after iniciar.
  logic [11:0] sv[0:5];
  logic [11:0] mv[0:1];
  logic [2:0]  cv[0:1];
  logic        dv[0:1];
  int cls_k = 0, cls_base = 0, cls_idx = 0, cls_dly = 0;

  always @(posedge clock) begin
    if (zera_classificador) fim_c <= 1'b0;
    if (iniciar) begin
      cls_dly <= 2;
      cls_idx <= (cls_k - cls_base < MAX_TENT) ? cls_k - cls_base : MAX_TENT - 1;
      cls_k   <= cls_k + 1;
    end else if (cls_dly != 0) begin
      cls_dly <= cls_dly - 1;
      if (cls_dly == 1) begin
        fim_c   <= 1'b1;
        desc_c  <= dv[cls_idx];
        media_c <= mv[cls_idx];
        cod_c   <= cv[cls_idx];
      end
    end
  end

  int trig_cnt = 0, ini_cnt = 0, excl_viol = 0;
  always @(negedge clock) begin
    if (trigger) trig_cnt <= trig_cnt + 1;
    if (iniciar) ini_cnt <= ini_cnt + 1;
    if (int'(trigger) + int'(zera_classificador) + int'(iniciar) > 1) excl_viol <= excl_viol + 1;
  end

  int          exp_att, trig0, ini0;
  logic [11:0] exp_m[0:2];

  task automatic prep_acq();
    logic [11:0] t;
    sens_q.delete();
    for (int i = 0; i < 3 * MAX_TENT; i++) sens_q.push_back(sv[i]);
    cls_base = cls_k;
    exp_att = 1;
    while (dv[exp_att-1] && exp_att < MAX_TENT) exp_att++;
    for (int i = 0; i < 3; i++) exp_m[i] = sv[3*(exp_att-1) + i];
`ifdef COLETOR_MEDIANA_EN
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2 - a; b++)
        if (exp_m[b] > exp_m[b+1]) begin t = exp_m[b]; exp_m[b] = exp_m[b+1]; exp_m[b+1] = t; end
`endif
    t = '0;
    trig0 = trig_cnt;
    ini0  = ini_cnt;
  endtask

  task automatic pulse_medir();
    medir = 1'b1;
    @(posedge clock);
    #1 medir = 1'b0;
  endtask

  task automatic wait_and_check(input bit chk_lat);
    int n;
    int last;
    n = 0;
    while (!pronto && !erro_timeout && n < 3000) begin
      @(posedge clock);
      #1 n++;
    end
    last = exp_att - 1;
    check("pronto", pronto, 1);
    if (chk_lat) check("latencia", n, LAT_1);
    check("erro_timeout", erro_timeout, 0);
    check("tentativas", tentativas, exp_att);
    check("descartada", descartada, dv[last]);
    check("media_final", media_final, mv[last]);
    check("classificacao_final", classificacao_final, cv[last]);
    check("medida1", medida1, exp_m[0]);
    check("medida2", medida2, exp_m[1]);
    check("medida3", medida3, exp_m[2]);
    check("triggers", trig_cnt - trig0, 3 * exp_att);
    check("iniciar_pulsos", ini_cnt - ini0, exp_att);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, n;
    zera_n = 1'b0;
    medir  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_trigger", trigger, 0);
    check("rst_pronto", pronto, 0);
    check("rst_erro", erro_timeout, 0);
    check("rst_tentativas", tentativas, 0);
    check("rst_medida1", medida1, 0);
    check("rst_media_final", media_final, 0);
    check("rst_iniciar", iniciar, 0);
    zera_n = 1'b1;
    @(posedge clock);
    #1 check("ocioso_sem_trigger", trigger, 0);

    // Single successful attempt
    sv = '{20, 21, 22, 0, 0, 0};
    dv = '{1'b0, 1'b0}; mv = '{21, 0}; cv = '{NORMAL, BAIXO};
    prep_acq(); pulse_medir(); wait_and_check(1);

    // Discard then accept
    sv = '{50, 51, 52, 60, 61, 62};
    dv = '{1'b1, 1'b0}; mv = '{11, 37}; cv = '{ALTO, BAIXO};
    prep_acq(); pulse_medir(); wait_and_check(0);

    // Retry budget exhausted
    sv = '{5, 6, 7, 8, 9, 10};
    dv = '{1'b1, 1'b1}; mv = '{5, 9}; cv = '{BAIXO, MUITO_ALTO};
    prep_acq(); pulse_medir(); wait_and_check(0);

    // Sensor silent after the second trigger
    sens_q.delete(); sens_q.push_back(12'd40);
    ini0 = ini_cnt;
    pulse_medir();
    seen = 0; n = 0;
    while (n < 200) begin
      if (trigger) seen++;
      if (seen == 2) break;
      @(posedge clock);
      #1 n++;
    end
    check("segundo_trigger", seen, 2);
    n = 0;
    while (!erro_timeout && n < 200) begin
      @(posedge clock);
      #1 n++;
    end
    check("erro_timeout", erro_timeout, 1);
    check("timeout_ciclos", n, 1 + TIMEOUT);
    check("timeout_pronto", pronto, 0);
    check("timeout_sem_iniciar", ini_cnt - ini0, 0);
    check("timeout_medida1", medida1, 40);
    sv = '{100, 200, 300, 0, 0, 0};
    dv = '{1'b0, 1'b0}; mv = '{200, 0}; cv = '{ALTO, BAIXO};
    prep_acq(); pulse_medir(); wait_and_check(1);

    // Reset during INTERVALO with medir held high
    sens_q.delete(); sens_q.push_back(12'd99);
    pulse_medir();
    repeat (5) @(posedge clock);
    #1 zera_n = 1'b0; medir = 1'b1;
    @(posedge clock);
    #1;
    check("rst_meio_trigger", trigger, 0);
    check("rst_meio_tentativas", tentativas, 0);
    check("rst_meio_medida1", medida1, 0);
    check("rst_meio_media_final", media_final, 0);
    check("rst_meio_pronto", pronto, 0);
    sv = '{70, 71, 72, 0, 0, 0};
    dv = '{1'b0, 1'b0}; mv = '{71, 0}; cv = '{NORMAL, BAIXO};
    prep_acq();
    zera_n = 1'b1;
    @(posedge clock);
    #1 medir = 1'b0;
    wait_and_check(1);

    // Stray pronto_sensor in INTERVALO, medir during ESPERA_CLASSIF
    sv = '{30, 10, 20, 0, 0, 0};
    dv = '{1'b0, 1'b0}; mv = '{20, 0}; cv = '{MUITO_ALTO, BAIXO};
    prep_acq(); pulse_medir();
    repeat (5) @(posedge clock);
    #1 poke_val = 12'd999; poke_ps = 1'b1;
    @(posedge clock);
    #1 poke_ps = 1'b0;
    n = 0;
    while (!iniciar && n < 200) begin
      @(posedge clock);
      #1 n++;
    end
    check("iniciar_visto", iniciar, 1);
    @(posedge clock);
    #1 medir = 1'b1;
    @(posedge clock);
    #1 medir = 1'b0;
    wait_and_check(0);

    // Randomized acquisitions
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 6; i++) sv[i] = 12'($urandom_range(4095));
      for (int i = 0; i < 2; i++) begin
        dv[i] = 1'($urandom_range(1));
        mv[i] = 12'($urandom_range(4095));
        case ($urandom_range(3))
          0: cv[i] = BAIXO;
          1: cv[i] = NORMAL;
          2: cv[i] = ALTO;
          default: cv[i] = MUITO_ALTO;
        endcase
      end
      prep_acq(); pulse_medir(); wait_and_check(!dv[0]);
    end

    check("pulsos_exclusivos", excl_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
